compare_serial: RTL and testbench
=================================

Name: compare_serial

Overview:
- Bit-serial magnitude comparator. Answers the same question as the parallel 8-bit `Compare` block (A >= B, unsigned).
- Operands are loaded on a start strobe and scanned MSB-first, one bit per clock. The result is returned with a one-cycle done pulse.
- Sits beside the parallel comparator in the lab datapath. It is the area-lean, handshaked counterpart for streams where operands arrive under control of a sequencer rather than as free-running combinational inputs.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- data_in  input  WIDTH  operand A, unsigned.
- data_in_0  input  WIDTH  operand B, unsigned.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse: result valid.
- ageb  output  1  1 when A >= B; held until the next accepted start.
- aeqb  output  1  1 when A == B; held like ageb.

Behaviour:
- Reset: interface fixed as one clock, clk; reset rst is synchronous and active-high. On rst=1 at a clock edge:
  - state=IDLE, shift registers and counter cleared.
  - busy=0, done=0, ageb=0, aeqb=0.
  - rst overrides start and any operation in progress; no done pulse is issued for the aborted compare.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T latches data_in into sa and data_in_0 into sb, and loads cnt=WIDTH-1.
  - Clears ageb and aeqb, then moves to SHIFT.
  - start=0 keeps the state in IDLE with results held.
- SHIFT (busy=1): each cycle compares sa[MSB] against sb[MSB].
  - sa=1, sb=0: ageb<=1, aeqb<=0, go to DONE.
  - sa=0, sb=1: ageb<=0, aeqb<=0, go to DONE.
  - Equal bits, cnt==0: ageb<=1, aeqb<=1, go to DONE.
  - Equal bits, cnt!=0: shift sa and sb left by 1, cnt<=cnt-1, stay in SHIFT.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored; it must be re-asserted in IDLE.
- start while busy or in DONE is ignored. data_in and data_in_0 are don't-care after the load edge.
- Latency, with the start edge at T and first differing bit at index i counted from the MSB (i = 0..WIDTH-1):
  - Differing operands: done high in cycle T+2+i.
  - Equal operands: done high in cycle T+WIDTH+1.
- cnt width is clog2(WIDTH). There is no wrap-around: cnt==0 always terminates the scan.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: COMPARE_SERIAL_EARLY_EXIT_EN.
- Defined: early termination on the first differing bit, as specified above.
- Undefined: the scan always runs the full WIDTH cycles.
  - The first difference is recorded in a sticky decided flag together with its result.
  - Later bits do not alter the result.
  - done occurs at fixed T+WIDTH+1 for all operands; ageb and aeqb values are identical to the defined case.

Decomposition:
- Package compare_pkg holds:
  - state enum cmp_state_t {IDLE, SHIFT, DONE};
  - localparam CMP_WIDTH_DEF = 8;
  - function for the counter width, clog2.
- One natural sub-module: compare_bit_cell. It is combinational: given a_bit, b_bit and the decided flag, it returns gt, lt and eq. It is instantiated once in compare_serial.

Test Plan:
- A=8'b10011001, B=8'b00011001, start at T -> done at T+2, ageb=1, aeqb=0; with the macro undefined, done at T+9, same values.
- A=8'b01101101, B=8'b11101101 -> done at T+2, ageb=0, aeqb=0.
- A=B=8'b10101101 -> done at T+9, ageb=1, aeqb=1; busy high T+1..T+8.
- A=8'b00100101, B=8'b00100100 (differ at LSB) -> done at T+9, ageb=1. Second start pulsed at T+3 (busy) is ignored: exactly one done pulse, and results are unchanged by the new inputs.
- Reset mid-operation: start A=8'b11101000, B=8'b11101001, then rst=1 at T+4 -> at T+5 busy=0, done=0, ageb=0, aeqb=0; no done pulse follows. A fresh start afterwards gives ageb=0 at T'+9.
- Back-to-back: start asserted continuously from T -> a new compare is accepted only in the IDLE cycle after each done. done pulses are spaced by latency+1, and there are no missed or duplicate pulses.

Source files
------------

// File: rtl/compare_pkg.sv
// compare_pkg: shared types and helpers for the bit-serial magnitude comparator.
//   cmp_state_t   : controller states (IDLE, SHIFT, DONE)
//   CMP_WIDTH_DEF : default operand width
//   cmp_clog2     : ceil(log2(value)), used to size the bit counter
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cmp_state_t;

  localparam int CMP_WIDTH_DEF = 8;

  function automatic int unsigned cmp_clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/compare_serial_if.sv
// compare_serial_if: handshake/operand bundle for compare_serial.
//   start     : load request (sequencer -> comparator)
//   data_in   : operand A, unsigned
//   data_in_0 : operand B, unsigned
//   busy      : scan in progress
//   done      : one-cycle result-valid pulse
//   ageb      : A >= B, held until the next accepted start
//   aeqb      : A == B, held like ageb
// master = sequencer side, slave = comparator side.
interface compare_serial_if
  import compare_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_in_0;
  logic             busy;
  logic             done;
  logic             ageb;
  logic             aeqb;

  modport master (
    output start, data_in, data_in_0,
    input  busy, done, ageb, aeqb
  );

  modport slave (
    input  start, data_in, data_in_0,
    output busy, done, ageb, aeqb
  );

endinterface

// File: rtl/compare_bit_cell.sv
// compare_bit_cell: combinational single-bit compare step.
//   a_bit, b_bit : current MSB of the A and B shift registers
//   decided      : an earlier bit already fixed the result
//   gt, lt       : this bit decides A > B / A < B (suppressed once decided)
//   eq           : bits equal and nothing decided yet
module compare_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic decided,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = ~decided &  a_bit & ~b_bit;
  assign lt = ~decided & ~a_bit &  b_bit;
  assign eq = ~decided & (a_bit ~^ b_bit);

endmodule

// File: rtl/compare_serial.sv
// compare_serial: bit-serial unsigned magnitude comparator (A >= B, A == B).
// Operands load on an accepted start in IDLE and are scanned MSB-first,
// one bit per clock; the result is announced with a one-cycle done pulse.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : compare_serial_if.slave (start, data_in, data_in_0,
//          busy, done, ageb, aeqb)
// Build option COMPARE_SERIAL_EARLY_EXIT_EN: when defined, the scan stops
// at the first differing bit; otherwise it always runs WIDTH cycles and a
// sticky decided flag freezes the result at the first difference.
module compare_serial
  import compare_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  compare_serial_if.slave   bus
);

  localparam int unsigned CW = cmp_clog2(WIDTH);

  cmp_state_t       state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ageb_q, ageb_n;
  logic             aeqb_q, aeqb_n;
  logic             decided, decided_n;
  logic             bit_gt, bit_lt, bit_eq;
  logic             finish;

  compare_bit_cell u_cell (
    .a_bit   (sa[WIDTH-1]),
    .b_bit   (sb[WIDTH-1]),
    .decided (decided),
    .gt      (bit_gt),
    .lt      (bit_lt),
    .eq      (bit_eq)
  );

`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
  assign finish = bit_gt | bit_lt | (cnt == '0);
`else
  assign finish = (cnt == '0);
`endif

  always_comb begin
    state_n   = state;
    sa_n      = sa;
    sb_n      = sb;
    cnt_n     = cnt;
    ageb_n    = ageb_q;
    aeqb_n    = aeqb_q;
    decided_n = decided;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sa_n      = bus.data_in;
          sb_n      = bus.data_in_0;
          cnt_n     = CW'(WIDTH - 1);
          ageb_n    = 1'b0;
          aeqb_n    = 1'b0;
          decided_n = 1'b0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_gt) begin
          ageb_n    = 1'b1;
          aeqb_n    = 1'b0;
          decided_n = 1'b1;
        end else if (bit_lt) begin
          ageb_n    = 1'b0;
          aeqb_n    = 1'b0;
          decided_n = 1'b1;
        end else if (bit_eq && (cnt == '0)) begin
          // every bit matched and nothing decided earlier
          ageb_n = 1'b1;
          aeqb_n = 1'b1;
        end
        if (finish) begin
          state_n = DONE;
        end else begin
          // counter is only stepped while it is non-zero, so it never wraps
          sa_n  = {sa[WIDTH-2:0], 1'b0};
          sb_n  = {sb[WIDTH-2:0], 1'b0};
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      ageb_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      decided <= 1'b0;
    end else begin
      state   <= state_n;
      sa      <= sa_n;
      sb      <= sb_n;
      cnt     <= cnt_n;
      ageb_q  <= ageb_n;
      aeqb_q  <= aeqb_n;
      decided <= decided_n;
    end
  end

  // decoded straight from registers: no input-to-output combinational path
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.ageb = ageb_q;
  assign bus.aeqb = aeqb_q;

endmodule

// File: tb/tb_compare_serial.sv
// tb_compare_serial: self-checking bench for compare_serial.
// A transaction-level model decides when a start is accepted, computes the
// expected result from A >= B / A == B and the expected done cycle, and
// queues it; a monitor on the falling edge pops and checks it when done is
// seen, and checks busy and held results every cycle.
// Honors COMPARE_SERIAL_EARLY_EXIT_EN for the expected latency.
module tb_compare_serial;

  localparam int WIDTH = 8;

  typedef struct {
    int   label;
    logic ge;
    logic eq;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  compare_serial_if #(.WIDTH(WIDTH)) bus ();

  compare_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_at  = 0;
  int   busy_lo  = 1;
  int   busy_hi  = 0;
  bit   chk_en   = 1'b0;
  logic idle_ge  = 1'b0;
  logic idle_eq  = 1'b0;

  function automatic void chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc + 1, got, exp);
    end
  endfunction

  function automatic int latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_SERIAL_EARLY_EXIT_EN
    for (int k = 0; k < WIDTH; k++) begin
      if (a[WIDTH-1-k] != b[WIDTH-1-k]) return 2 + k;
    end
`endif
    return WIDTH + 1;
  endfunction

  // Reference model: acceptance and expected result per rising edge.
  always @(posedge clk) begin : model
    int lat;
    cyc++;
    if (rst) begin
      sbq.delete();
      done_at = cyc;
      busy_lo = 1;
      busy_hi = 0;
      idle_ge = 1'b0;
      idle_eq = 1'b0;
    end else if (bus.start && cyc > done_at) begin
      lat     = latency(bus.data_in, bus.data_in_0);
      done_at = cyc + lat;
      busy_lo = cyc + 1;
      busy_hi = cyc + lat - 1;
      sbq.push_back('{cyc + lat, bus.data_in >= bus.data_in_0,
                      bus.data_in == bus.data_in_0});
    end
  end

  // Monitor: the cycle observed at this falling edge is labelled cyc+1.
  always @(negedge clk) begin : monitor
    int   label;
    bit   exp_done;
    bit   exp_busy;
    exp_t e;
    if (chk_en) begin
      label    = cyc + 1;
      exp_done = (sbq.size() > 0) && (sbq[0].label <= label);
      exp_busy = (label >= busy_lo) && (label <= busy_hi);
      chk("done", bus.done, exp_done);
      if (exp_done) begin
        e = sbq.pop_front();
        chk("done_cycle", 1'(e.label == label), 1'b1);
        chk("ageb", bus.ageb, e.ge);
        chk("aeqb", bus.aeqb, e.eq);
        idle_ge = e.ge;
        idle_eq = e.eq;
      end
      chk("busy", bus.busy, exp_busy);
      if (!exp_busy && !exp_done) begin
        chk("ageb_held", bus.ageb, idle_ge);
        chk("aeqb_held", bus.aeqb, idle_eq);
      end
    end
  end

  task automatic drive(input bit s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit r);
    @(negedge clk);
    bus.start     = s;
    bus.data_in   = a;
    bus.data_in_0 = b;
    rst           = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
  endtask

  task automatic rand_cycle(input bit s, input bit r);
    logic [WIDTH-1:0] a, b;
    a = WIDTH'($urandom);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      default: b = WIDTH'($urandom);
    endcase
    drive(s, a, b, r);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.data_in   = '0;
    bus.data_in_0 = '0;
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    chk_en = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    idle(2);

    drive(1'b1, 8'b10011001, 8'b00011001, 1'b0); idle(12);
    drive(1'b1, 8'b01101101, 8'b11101101, 1'b0); idle(12);
    drive(1'b1, 8'b10101101, 8'b10101101, 1'b0); idle(12);

    // second start while busy must be ignored
    drive(1'b1, 8'b00100101, 8'b00100100, 1'b0);
    idle(2);
    drive(1'b1, 8'b00000000, 8'b11111111, 1'b0);
    idle(10);

    // reset in the middle of a compare, then a fresh compare
    drive(1'b1, 8'b11101000, 8'b11101001, 1'b0);
    idle(3);
    drive(1'b0, '0, '0, 1'b1);
    idle(3);
    drive(1'b1, 8'b11101000, 8'b11101001, 1'b0);
    idle(12);

    // start held high: back-to-back compares
    for (int i = 0; i < 60; i++) rand_cycle(1'b1, 1'b0);
    idle(12);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      rand_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
    idle(WIDTH + 4);

    chk("drained", 1'(sbq.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
